pll_loop_filter: RTL and testbench

Proportional-integral loop filter between the ADC I2C controller and the DAC serial controller in the PLL datapath. Takes each new 8-bit ADC sample, computes the phase/level error against a setpoint, and updates a saturating integrator. Produces a clamped 16-bit DAC code, handed to the DAC controller through a valid/ready handshake. It replaces the bare sample-to-DAC latch and runs on the divided system clock.

---
 rtl/pll_loop_filter.sv | 153 +++++++++++++++
 tb/tb_pll_loop_filter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pll_loop_filter.sv
// rtl/pll_loop_filter.sv - PI loop filter from ADC sample to clamped DAC code
module pll_loop_filter #(
   parameter int          SETPOINT = 128,
   parameter int          KP_SHIFT = 4,
   parameter int          KI_SHIFT = 6,
   parameter int          INT_W    = 24,
   parameter logic [15:0] OFFSET   = 16'h8000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  sample_in,
   input  logic        sample_valid,
   input  logic        clr_int,
   output logic [15:0] dac_word,
   output logic        dac_valid,
   input  logic        dac_ready,
   output logic        busy,
   output logic        overrun
);

   // Sum width: 16-bit offset + 17-bit P term + up to 24-bit I term, signed.
   localparam int SW = 27;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ERR   = 3'd1,
      INTEG = 3'd2,
      SUM   = 3'd3,
      HOLD  = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic                    sv_d;
   logic                    new_sample;
   logic [7:0]              pend_data;
   logic                    pend_full;
   logic [7:0]              work;
   logic signed [8:0]       err;
   logic signed [INT_W-1:0] integ;

   logic signed [INT_W:0]   int_sum;
   logic signed [INT_W-1:0] int_sat;
   logic signed [SW-1:0]    err_ext;
   logic signed [SW-1:0]    int_ext;
   logic signed [SW-1:0]    p_term;
   logic signed [SW-1:0]    i_term;
   logic signed [SW-1:0]    sum_full;
   logic [15:0]             sum_clamp;

   localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

   // A held-high sample_valid yields a single rising edge, hence one sample.
   assign new_sample = sample_valid & ~sv_d;
   assign busy       = (state != IDLE);

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state: fixed pipeline ERR->INTEG->SUM, then wait in HOLD for the DAC.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (new_sample || pend_full) state_nxt = ERR;
         ERR:     state_nxt = INTEG;
         INTEG:   state_nxt = SUM;
         SUM:     state_nxt = HOLD;
         HOLD:    if (dac_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Sample intake: edge detect, working sample load and one-deep pending slot.
   // The buffered sample is older, so IDLE always drains it before a fresh one.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sv_d      <= 1'b0;
         pend_data <= 8'd0;
         pend_full <= 1'b0;
         work      <= 8'd0;
         overrun   <= 1'b0;
      end else begin
         sv_d <= sample_valid;
         if (state == IDLE) begin
            if (pend_full) begin
               work <= pend_data;
               if (new_sample) pend_data <= sample_in;
               else            pend_full <= 1'b0;
            end else if (new_sample) begin
               work <= sample_in;
            end
         end else if (new_sample) begin
            pend_data <= sample_in;
            pend_full <= 1'b1;
            if (pend_full) overrun <= 1'b1;
         end
      end
   end

   // Error register: unsigned sample minus setpoint, always fits 9 bits signed.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                err <= 9'sd0;
      else if (state == ERR)  err <= $signed({1'b0, work}) - $signed(9'(SETPOINT));
   end

   // Saturating accumulate: one guard bit detects overflow in either direction.
   assign int_sum = $signed({integ[INT_W-1], integ}) +
                    $signed({{(INT_W+1-9){err[8]}}, err});

   always_comb begin
      int_sat = int_sum[INT_W-1:0];
      if (int_sum[INT_W] != int_sum[INT_W-1])
         int_sat = int_sum[INT_W] ? INT_MIN : INT_MAX;
   end

   // Integrator: clear has priority over the INTEG update.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                  integ <= '0;
      else if (clr_int)         integ <= '0;
      else if (state == INTEG)  integ <= int_sat;
   end

   // P+I+offset in a wide signed domain, then clamped to the 16-bit DAC range.
   assign err_ext  = $signed({{(SW-9){err[8]}}, err});
   assign int_ext  = $signed({{(SW-INT_W){integ[INT_W-1]}}, integ});
   assign p_term   = err_ext <<< KP_SHIFT;
   assign i_term   = int_ext >>> KI_SHIFT;
   assign sum_full = $signed({{(SW-16){1'b0}}, OFFSET}) + p_term + i_term;

   always_comb begin
      sum_clamp = sum_full[15:0];
      if (sum_full[SW-1])             sum_clamp = 16'h0000;
      else if (|sum_full[SW-2:16])    sum_clamp = 16'hFFFF;
   end

   // Output register: dac_word keeps its last code after the DAC accepts it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dac_word  <= OFFSET;
         dac_valid <= 1'b0;
      end else if (state == SUM) begin
         dac_word  <= sum_clamp;
         dac_valid <= 1'b1;
      end else if (state == HOLD && dac_ready) begin
         dac_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pll_loop_filter.sv
// tb/tb_pll_loop_filter.sv - directed table-driven bench for pll_loop_filter
module tb_pll_loop_filter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  sample_in = 8'd0;
   logic        sample_valid = 1'b0;
   logic        clr_int = 1'b0;
   logic        dac_ready = 1'b0;

   logic [15:0] dw [4];
   logic        dv [4];
   logic        bz [4];
   logic        ov [4];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   // 0: defaults
   pll_loop_filter u_def (
      .CLK(CLK), .RST(RST), .sample_in(sample_in), .sample_valid(sample_valid),
      .clr_int(clr_int), .dac_word(dw[0]), .dac_valid(dv[0]), .dac_ready(dac_ready),
      .busy(bz[0]), .overrun(ov[0]));

   // 1: high gain, setpoint 0 (positive clamp)
   pll_loop_filter #(.SETPOINT(0), .KP_SHIFT(8)) u_hi (
      .CLK(CLK), .RST(RST), .sample_in(sample_in), .sample_valid(sample_valid),
      .clr_int(clr_int), .dac_word(dw[1]), .dac_valid(dv[1]), .dac_ready(dac_ready),
      .busy(bz[1]), .overrun(ov[1]));

   // 2: high gain, setpoint 255 (negative clamp)
   pll_loop_filter #(.SETPOINT(255), .KP_SHIFT(8)) u_lo (
      .CLK(CLK), .RST(RST), .sample_in(sample_in), .sample_valid(sample_valid),
      .clr_int(clr_int), .dac_word(dw[2]), .dac_valid(dv[2]), .dac_ready(dac_ready),
      .busy(bz[2]), .overrun(ov[2]));

   // 3: narrow integrator, unity gains (integrator saturation)
   pll_loop_filter #(.SETPOINT(0), .KP_SHIFT(0), .KI_SHIFT(0), .INT_W(12)) u_sat (
      .CLK(CLK), .RST(RST), .sample_in(sample_in), .sample_valid(sample_valid),
      .clr_int(clr_int), .dac_word(dw[3]), .dac_valid(dv[3]), .dac_ready(dac_ready),
      .busy(bz[3]), .overrun(ov[3]));

   typedef struct {
      bit               rst;
      logic [7:0]       smp;
      logic [3:0][15:0] exp;   // [3]=sat [2]=lo [1]=hi [0]=def
   } vec_t;

   vec_t vec [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // Pulse one sample, then count negedges until dac_valid (bounded).
   task automatic run_sample(input logic [7:0] v, output int lat);
      @(negedge CLK);
      sample_in    = v;
      sample_valid = 1'b1;
      @(negedge CLK);
      sample_valid = 1'b0;
      lat = 1;
      while (!dv[0] && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
   endtask

   task automatic accept(input logic [15:0] word);
      dac_ready = 1'b1;
      @(negedge CLK);
      dac_ready = 1'b0;
      chk("valid_drop", 32'(dv[0]), 32'd0);
      chk("word_keep", 32'(dw[0]), 32'(word));
   endtask

   initial begin
      int lat;
      int w;

      vec[0] = '{1'b1, 8'd128, {16'h8100, 16'h00FE, 16'hFFFF, 16'h8000}};
      vec[1] = '{1'b1, 8'd200, {16'h8190, 16'h48FF, 16'hFFFF, 16'h8481}};
      vec[2] = '{1'b0, 8'd0,   {16'h80C8, 16'h0000, 16'h8003, 16'h77FF}};
      vec[3] = '{1'b1, 8'd255, {16'h81FE, 16'h8000, 16'hFFFF, 16'h87F1}};
      vec[4] = '{1'b1, 8'd0,   {16'h8000, 16'h0000, 16'h8000, 16'h77FE}};

      repeat (2) @(negedge CLK);
      RST = 1'b0;
      chk("rst_word", 32'(dw[0]), 32'h8000);
      chk("rst_valid", 32'(dv[0]), 32'd0);
      chk("rst_busy", 32'(bz[0]), 32'd0);
      chk("rst_overrun", 32'(ov[0]), 32'd0);

      // Table: one sample per row, all four parameter sets checked together.
      for (int i = 0; i < 5; i++) begin
         if (vec[i].rst) do_reset();
         run_sample(vec[i].smp, lat);
         chk($sformatf("latency_%0d", i), 32'(lat), 32'd4);
         for (int k = 0; k < 4; k++)
            chk($sformatf("word_%0d_%0d", i, k), 32'(dw[k]), 32'(vec[i].exp[k]));
         accept(vec[i].exp[0]);
      end

      // Integrator saturation on the 12-bit instance, no wrap to negative.
      do_reset();
      for (int n = 1; n <= 12; n++) begin
         run_sample(8'd255, lat);
         if (n == 8)  chk("sat_8", 32'(dw[3]), 32'h88F7);
         if (n == 12) chk("sat_12", 32'(dw[3]), 32'h88FE);
         accept(dw[0]);
      end

      // Overrun: A processed and held, B buffered then replaced by C.
      do_reset();
      @(negedge CLK); sample_in = 8'd200; sample_valid = 1'b1;
      @(negedge CLK); sample_valid = 1'b0;
      @(negedge CLK); sample_in = 8'd0;   sample_valid = 1'b1;
      @(negedge CLK); sample_valid = 1'b0;
      @(negedge CLK); sample_in = 8'd255; sample_valid = 1'b1;
      @(negedge CLK); sample_valid = 1'b0;
      chk("ovr_flag", 32'(ov[0]), 32'd1);
      chk("ovr_valid_a", 32'(dv[0]), 32'd1);
      chk("ovr_word_a", 32'(dw[0]), 32'h8481);
      repeat (3) @(negedge CLK);
      chk("ovr_hold_valid", 32'(dv[0]), 32'd1);
      chk("ovr_hold_word", 32'(dw[0]), 32'h8481);
      accept(16'h8481);
      w = 0;
      while (!dv[0] && w < 20) begin
         @(negedge CLK);
         w++;
      end
      chk("ovr_wait_c", 32'(w < 20), 32'd1);
      chk("ovr_word_c", 32'(dw[0]), 32'h87F3);
      chk("ovr_busy", 32'(bz[0]), 32'd1);

      // Asynchronous reset while holding an unaccepted output.
      #2 RST = 1'b1;
      #1;
      chk("arst_valid", 32'(dv[0]), 32'd0);
      chk("arst_word", 32'(dw[0]), 32'h8000);
      chk("arst_busy", 32'(bz[0]), 32'd0);
      chk("arst_overrun", 32'(ov[0]), 32'd0);
      @(negedge CLK);
      RST = 1'b0;

      // clr_int during INTEG: output uses integ=0, next sample starts from 0.
      do_reset();
      @(negedge CLK); sample_in = 8'd200; sample_valid = 1'b1;
      @(negedge CLK); sample_valid = 1'b0;
      @(negedge CLK); clr_int = 1'b1;
      @(negedge CLK); clr_int = 1'b0;
      @(negedge CLK);
      chk("clr_valid", 32'(dv[0]), 32'd1);
      chk("clr_word", 32'(dw[0]), 32'h8480);
      accept(16'h8480);
      run_sample(8'd200, lat);
      chk("clr_next_word", 32'(dw[0]), 32'h8481);
      accept(16'h8481);

      // sample_valid held high counts as one sample.
      do_reset();
      @(negedge CLK); sample_in = 8'd128; sample_valid = 1'b1;
      w = 0;
      while (!dv[0] && w < 20) begin
         @(negedge CLK);
         w++;
      end
      chk("hold_hi_wait", 32'(w < 20), 32'd1);
      accept(16'h8000);
      repeat (8) @(negedge CLK);
      chk("hold_hi_valid", 32'(dv[0]), 32'd0);
      chk("hold_hi_busy", 32'(bz[0]), 32'd0);
      sample_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
